// File: rtl/serial_shift_right_if.sv
// Operand/result bundle between the ALU issue stage and the serial right shifter.
// master drives the request side; slave (the shifter) drives status and result.
interface serial_shift_right_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               Start;
    logic [1:0]         Mode;
    logic [WIDTH-1:0]   DataA;
    logic [SHAMT_W-1:0] ShiftAmount;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   Result;

    modport master (
        output Start,
        output Mode,
        output DataA,
        output ShiftAmount,
        input  Busy,
        input  Done,
        input  Result
    );

    modport slave (
        input  Start,
        input  Mode,
        input  DataA,
        input  ShiftAmount,
        output Busy,
        output Done,
        output Result
    );
endinterface

// File: rtl/serial_shift_right.sv
// Purpose: serial SRL/SRA (and ROR when SERIAL_SHIFT_RIGHT_ROTATE_EN is defined), one bit per clock.
// Latency: Start accepted in cycle N -> Done pulse in cycle N+1+ShiftAmount.
// Backpressure: Start is ignored while Busy; a Start in the Done cycle is accepted back-to-back.
module serial_shift_right #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    serial_shift_right_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   result_nxt;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] count_nxt;
    logic [1:0]         mode_q;
    logic [1:0]         mode_nxt;
    logic               fill;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            count  <= '0;
            mode_q <= 2'd0;
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            count  <= count_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Bit entering at the MSB on each step; reserved mode 3 behaves as SRL.
    always_comb begin
        fill = 1'b0;
        case (mode_q)
            2'd1: fill = result[WIDTH-1];
`ifdef SERIAL_SHIFT_RIGHT_ROTATE_EN
            2'd2: fill = result[0];
`else
            2'd2: fill = 1'b0;
`endif
            default: fill = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        count_nxt  = count;
        mode_nxt   = mode_q;
        case (state)
            IDLE, DONE: begin
                if (bus.Start) begin
                    result_nxt = bus.DataA;
                    count_nxt  = bus.ShiftAmount;
                    mode_nxt   = bus.Mode;
                    state_nxt  = (bus.ShiftAmount != '0) ? SHIFT : DONE;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                result_nxt = {fill, result[WIDTH-1:1]};
                count_nxt  = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Busy   = (state == SHIFT);
    assign bus.Done   = (state == DONE);
    assign bus.Result = result;

endmodule

// File: tb/tb_serial_shift_right.sv
// Directed bench for serial_shift_right: latency, fill modes, busy-ignore, back-to-back and reset abort.
module tb_serial_shift_right;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    serial_shift_right_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    serial_shift_right #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one op starting in cycle N and returns in the Done cycle; lat counts cycles from N.
    task automatic run_op(input logic [31:0] a, input logic [4:0] amt, input logic [1:0] m,
                          output int lat, output int busy_cyc, output bit overlap,
                          output bit timed_out);
        @(negedge clock);
        bus.Start       = 1'b1;
        bus.DataA       = a;
        bus.ShiftAmount = amt;
        bus.Mode        = m;
        @(posedge clock);
        #1;
        bus.Start       = 1'b0;
        bus.DataA       = 32'hDEAD_BEEF;
        bus.ShiftAmount = 5'd7;
        bus.Mode        = 2'd1;
        lat       = 1;
        busy_cyc  = 0;
        overlap   = 1'b0;
        timed_out = 1'b0;
        while (!bus.Done) begin
            if (bus.Busy) busy_cyc++;
            if (lat >= 64) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        if (bus.Busy && bus.Done) overlap = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        tests++;
        if (bus.Result !== 32'h0) begin
            fails++;
            $display("FAIL reset_result: got %h want %h", bus.Result, 32'h0);
        end
        tests++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", bus.Busy, bus.Done);
        end
    endtask

    task automatic test_srl();
        int lat, bc; bit ov, to;
        run_op(32'hF000_0001, 5'd4, 2'd0, lat, bc, ov, to);
        tests++;
        if (to !== 1'b0 || lat !== 5) begin
            fails++;
            $display("FAIL srl_latency: got %0d (timeout=%0d) want 5", lat, to);
        end
        tests++;
        if (bus.Result !== 32'h0F00_0000) begin
            fails++;
            $display("FAIL srl_result: got %h want %h", bus.Result, 32'h0F00_0000);
        end
        tests++;
        if (bc !== 4 || ov !== 1'b0) begin
            fails++;
            $display("FAIL srl_busy: got busy_cycles=%0d overlap=%0d want 4 0", bc, ov);
        end
    endtask

    task automatic test_sra_max();
        int lat, bc; bit ov, to;
        run_op(32'h8000_0000, 5'd31, 2'd1, lat, bc, ov, to);
        tests++;
        if (to !== 1'b0 || lat !== 32) begin
            fails++;
            $display("FAIL sra_latency: got %0d (timeout=%0d) want 32", lat, to);
        end
        tests++;
        if (bus.Result !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sra_result: got %h want %h", bus.Result, 32'hFFFF_FFFF);
        end
        tests++;
        if (bc !== 31 || ov !== 1'b0) begin
            fails++;
            $display("FAIL sra_busy: got busy_cycles=%0d overlap=%0d want 31 0", bc, ov);
        end
    endtask

    task automatic test_zero_amount();
        int lat, bc; bit ov, to;
        run_op(32'h1234_5678, 5'd0, 2'd1, lat, bc, ov, to);
        tests++;
        if (to !== 1'b0 || lat !== 1) begin
            fails++;
            $display("FAIL zero_latency: got %0d (timeout=%0d) want 1", lat, to);
        end
        tests++;
        if (bus.Result !== 32'h1234_5678) begin
            fails++;
            $display("FAIL zero_result: got %h want %h", bus.Result, 32'h1234_5678);
        end
        tests++;
        if (bc !== 0) begin
            fails++;
            $display("FAIL zero_busy: got busy_cycles=%0d want 0", bc);
        end
    endtask

    task automatic test_other_modes();
        int lat, bc; bit ov, to;
        run_op(32'h7000_0000, 5'd4, 2'd1, lat, bc, ov, to);
        tests++;
        if (bus.Result !== 32'h0700_0000) begin
            fails++;
            $display("FAIL sra_positive: got %h want %h", bus.Result, 32'h0700_0000);
        end
        run_op(32'h8000_0000, 5'd4, 2'd3, lat, bc, ov, to);
        tests++;
        if (bus.Result !== 32'h0800_0000) begin
            fails++;
            $display("FAIL mode3_srl: got %h want %h", bus.Result, 32'h0800_0000);
        end
    endtask

    task automatic test_rotate();
        int lat, bc; bit ov, to;
        logic [31:0] exp;
`ifdef SERIAL_SHIFT_RIGHT_ROTATE_EN
        exp = 32'h8000_0001;
`else
        exp = 32'h0000_0001;
`endif
        run_op(32'h0000_0003, 5'd1, 2'd2, lat, bc, ov, to);
        tests++;
        if (to !== 1'b0 || lat !== 2) begin
            fails++;
            $display("FAIL rotate_latency: got %0d (timeout=%0d) want 2", lat, to);
        end
        tests++;
        if (bus.Result !== exp) begin
            fails++;
            $display("FAIL rotate_result: got %h want %h", bus.Result, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        bus.Start = 1'b1; bus.DataA = 32'h0000_0100; bus.ShiftAmount = 5'd4; bus.Mode = 2'd0;
        @(posedge clock); #1;
        bus.Start = 1'b0;
        @(posedge clock); #1;
        bus.Start = 1'b1; bus.DataA = 32'hFFFF_FFFF; bus.ShiftAmount = 5'd1; bus.Mode = 2'd1;
        @(posedge clock); #1;
        bus.Start = 1'b0;
        tests++;
        if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_flags: got busy=%b done=%b want 1 0", bus.Busy, bus.Done);
        end
        lat = 3;
        while (!bus.Done && lat < 64) begin
            @(posedge clock); #1;
            lat++;
        end
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL busy_ignore_latency: got %0d want 5", lat);
        end
        tests++;
        if (bus.Result !== 32'h0000_0010) begin
            fails++;
            $display("FAIL busy_ignore_result: got %h want %h", bus.Result, 32'h0000_0010);
        end
        bus.Start = 1'b1; bus.DataA = 32'h0000_0010; bus.ShiftAmount = 5'd1; bus.Mode = 2'd0;
        @(posedge clock); #1;
        bus.Start = 1'b0;
        tests++;
        if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_shift_flags: got busy=%b done=%b want 1 0", bus.Busy, bus.Done);
        end
        @(posedge clock); #1;
        tests++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Result !== 32'h0000_0008) begin
            fails++;
            $display("FAIL b2b_done: got done=%b busy=%b result=%h want 1 0 %h",
                     bus.Done, bus.Busy, bus.Result, 32'h0000_0008);
        end
        @(posedge clock); #1;
        tests++;
        if (bus.Done !== 1'b0 || bus.Result !== 32'h0000_0008) begin
            fails++;
            $display("FAIL done_pulse_hold: got done=%b result=%h want 0 %h",
                     bus.Done, bus.Result, 32'h0000_0008);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        @(negedge clock);
        bus.Start = 1'b1; bus.DataA = 32'hABCD_1234; bus.ShiftAmount = 5'd10; bus.Mode = 2'd0;
        @(posedge clock); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tests++;
        if (bus.Result !== 32'h0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_op: got result=%h busy=%b done=%b want 0 0 0",
                     bus.Result, bus.Busy, bus.Done);
        end
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (bus.Done || bus.Busy) done_seen++;
        end
        tests++;
        if (done_seen !== 0) begin
            fails++;
            $display("FAIL reset_no_done: got %0d active cycles want 0", done_seen);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.Start       = 1'b0;
        bus.DataA       = 32'h0;
        bus.ShiftAmount = 5'd0;
        bus.Mode        = 2'd0;
        test_reset();
        test_srl();
        test_sra_max();
        test_zero_amount();
        test_other_modes();
        test_rotate();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
